// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first active request at or after ptr.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    idx,
   output logic             found
);

   logic [IW-1:0] cand;

   always_comb begin
      idx   = ptr;
      found = 1'b0;
      cand  = '0;
      // Scan from the farthest candidate back to ptr so the nearest request is written last and wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = IW'((int'(ptr) + k) % N_REQ);
         if (req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ producers, locking per burst
// with a MAX_BURST cap that forces a hand-off.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  N_REQ      = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  MAX_BURST  = 16,
   localparam int IW         = idx_w(N_REQ),
   localparam int CW         = cnt_w(MAX_BURST)
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [N_REQ-1:0]            REQ,
   input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
   input  logic [N_REQ-1:0]            REQ_LAST,
   output logic [N_REQ-1:0]            ACK,
   input  logic                        FULL,
   output logic                        W_INC,
   output logic [DATA_WIDTH-1:0]       WR_DATA,
   output logic [IW-1:0]               GNT_ID,
   output logic                        BUSY,
   output logic                        BURST_CUT
);

   arb_state_e    state_q;
   logic [IW-1:0] gnt_q, rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] win_idx, sel;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic          burst_cut_q;
   logic          win_found, accept, last;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
      .req   (REQ),
      .ptr   (rr_ptr_q),
      .idx   (win_idx),
      .found (win_found)
   );

   always_comb begin
      if (state_q == LOCK)  sel = gnt_q;
      else if (win_found)   sel = win_idx;
      else                  sel = rr_ptr_q;
   end

   // RST gates acceptance so nothing is written or acknowledged while reset is held.
   assign accept      = RST & REQ[sel] & ~FULL;
   assign last        = REQ_LAST[sel];
   assign rr_ptr_d    = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
   assign burst_cnt_d = burst_cnt_q + CW'(1);

   assign W_INC     = accept;
   assign ACK       = accept ? (N_REQ'(1) << sel) : '0;
   assign GNT_ID    = sel;
   assign BUSY      = (state_q == LOCK);
   assign BURST_CUT = burst_cut_q;

   always_comb begin
      WR_DATA = REQ_DATA[DATA_WIDTH-1:0];
      for (int i = 1; i < N_REQ; i++) begin
         if (IW'(i) == sel) WR_DATA = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         burst_cut_q <= 1'b0;
      end else begin
         burst_cut_q <= 1'b0;
         if (accept) begin
            if (state_q == IDLE) begin
               if (!last && MAX_BURST > 1) begin
                  state_q     <= LOCK;
                  gnt_q       <= sel;
                  burst_cnt_q <= CW'(1);
               end else begin
                  rr_ptr_q <= rr_ptr_d;
               end
            end else if (last || burst_cnt_d == CW'(MAX_BURST)) begin
               // Release; without a last marker this is a forced cut and the rest re-arbitrates.
               state_q     <= IDLE;
               rr_ptr_q    <= rr_ptr_d;
               burst_cnt_q <= '0;
               burst_cut_q <= ~last;
            end else begin
               burst_cnt_q <= burst_cnt_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: two arbiters (MAX_BURST 16 and 4) driven by per-instance producer queues
// and checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int NI = 2;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } word_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic full  = 1'b0;
   logic full_v = 1'b0;

   logic [N-1:0]    req   [NI];
   logic [N*DW-1:0] rdata [NI];
   logic [N-1:0]    rlast [NI];
   logic [N-1:0]    ack   [NI];
   logic            winc  [NI];
   logic [DW-1:0]   wdat  [NI];
   logic [1:0]      gnt   [NI];
   logic            busy  [NI];
   logic            cut   [NI];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(gi == 0 ? 16 : 4)) u_dut (
         .CLK       (clk),
         .RST       (rst_n),
         .REQ       (req[gi]),
         .REQ_DATA  (rdata[gi]),
         .REQ_LAST  (rlast[gi]),
         .ACK       (ack[gi]),
         .FULL      (full),
         .W_INC     (winc[gi]),
         .WR_DATA   (wdat[gi]),
         .GNT_ID    (gnt[gi]),
         .BUSY      (busy[gi]),
         .BURST_CUT (cut[gi])
      );
   end

   word_t pq [NI][N][$];
   int    m_owner [NI];
   int    m_ptr   [NI];
   int    m_cnt   [NI];
   bit    m_cut   [NI];
   int    m_g     [NI];
   bit    m_acc   [NI];
   int    log_p   [NI][$];
   int    log_d   [NI][$];
   int    cuts    [NI];
   int    busy_wr [NI];
   int    cut_at  [NI];
   int    checks   = 0;
   int    failures = 0;

   function automatic int mb(input int i);
      return (i == 0) ? 16 : 4;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_q(input string name, input int act[$], input int exp[$]);
      chk({name, " len"}, act.size(), exp.size());
      for (int k = 0; k < exp.size(); k++)
         chk($sformatf("%s[%0d]", name, k), (k < act.size()) ? act[k] : -1, exp[k]);
   endtask

   // mode 0: last on final word, 1: every word is a single burst, 2: never last
   task automatic load(input int p, input int n, input int base, input int mode);
      word_t w;
      for (int i = 0; i < NI; i++)
         for (int k = 0; k < n; k++) begin
            w.data = DW'(base + k);
            w.last = (mode == 1) || (mode == 0 && k == n - 1);
            pq[i][p].push_back(w);
         end
   endtask

   task automatic start();
      for (int i = 0; i < NI; i++) begin
         for (int p = 0; p < N; p++) pq[i][p].delete();
         log_p[i].delete();
         log_d[i].delete();
         cuts[i] = 0;
         busy_wr[i] = 0;
         cut_at[i] = -1;
      end
      full_v = 1'b0;
   endtask

   task automatic compare_one(input int i);
      int g;
      bit acc;
      if (!rst_n) begin
         m_owner[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0; m_cut[i] = 0;
      end
      g = m_ptr[i];
      if (m_owner[i] >= 0) g = m_owner[i];
      else begin
         for (int k = 0; k < N; k++) begin
            if (pq[i][(m_ptr[i] + k) % N].size() > 0) begin
               g = (m_ptr[i] + k) % N;
               break;
            end
         end
      end
      acc = rst_n && !full && (pq[i][g].size() > 0);
      m_g[i] = g;
      m_acc[i] = acc;
      chk($sformatf("i%0d W_INC", i), int'(winc[i]), int'(acc));
      chk($sformatf("i%0d ACK", i), int'(ack[i]), acc ? (1 << g) : 0);
      if (acc) chk($sformatf("i%0d WR_DATA", i), int'(wdat[i]), int'(pq[i][g][0].data));
      chk($sformatf("i%0d GNT_ID", i), int'(gnt[i]), g);
      chk($sformatf("i%0d BUSY", i), int'(busy[i]), int'(m_owner[i] >= 0));
      chk($sformatf("i%0d BURST_CUT", i), int'(cut[i]), int'(m_cut[i]));
   endtask

   task automatic observe_one(input int i);
      int ap;
      if (cut[i]) begin
         cuts[i]++;
         if (cut_at[i] < 0) cut_at[i] = log_p[i].size();
      end
      if (winc[i]) begin
         ap = -1;
         for (int p = 0; p < N; p++) if (ack[i][p]) ap = p;
         log_p[i].push_back(ap);
         log_d[i].push_back(int'(wdat[i]));
         if (busy[i]) busy_wr[i]++;
      end
   endtask

   task automatic update_one(input int i);
      word_t w;
      bit    was_locked;
      m_cut[i] = 1'b0;
      if (!rst_n) begin
         m_owner[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0;
      end else if (m_acc[i]) begin
         w = pq[i][m_g[i]].pop_front();
         was_locked = (m_owner[i] >= 0);
         m_cnt[i]++;
         if (w.last || m_cnt[i] == mb(i)) begin
            m_cut[i]   = was_locked && !w.last;
            m_owner[i] = -1;
            m_cnt[i]   = 0;
            m_ptr[i]   = (m_g[i] + 1) % N;
         end else begin
            m_owner[i] = m_g[i];
         end
      end
   endtask

   task automatic cycle(input bit rst_val, input bit drop_rst);
      @(negedge clk);
      rst_n = rst_val;
      full  = full_v;
      for (int i = 0; i < NI; i++)
         for (int p = 0; p < N; p++) begin
            if (pq[i][p].size() > 0) begin
               req[i][p] = 1'b1;
               rdata[i][p*DW +: DW] = pq[i][p][0].data;
               rlast[i][p] = pq[i][p][0].last;
            end else begin
               req[i][p] = 1'b0;
               rdata[i][p*DW +: DW] = '0;
               rlast[i][p] = 1'b0;
            end
         end
      #1;
      for (int i = 0; i < NI; i++) compare_one(i);
      if (drop_rst) begin
         rst_n = 1'b0;
         #1;
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d async rst W_INC", i), int'(winc[i]), 0);
            chk($sformatf("i%0d async rst ACK", i), int'(ack[i]), 0);
            chk($sformatf("i%0d async rst BUSY", i), int'(busy[i]), 0);
            chk($sformatf("i%0d async rst BURST_CUT", i), int'(cut[i]), 0);
         end
      end
      for (int i = 0; i < NI; i++) begin
         observe_one(i);
         update_one(i);
      end
   endtask

   task automatic run(input int n);
      repeat (n) cycle(1'b1, 1'b0);
   endtask

   task automatic reset_pulse();
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
   endtask

   initial begin
      int e[$];
      int d[$];
      for (int i = 0; i < NI; i++) begin
         req[i] = '0; rdata[i] = '0; rlast[i] = '0;
         m_owner[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0; m_cut[i] = 0;
         m_g[i] = 0; m_acc[i] = 0;
      end

      // reset with every producer requesting
      start();
      for (int p = 0; p < N; p++) load(p, 1, p * 16, 1);
      cycle(1'b0, 1'b0);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("s1 i%0d rst W_INC", i), int'(winc[i]), 0);
         chk($sformatf("s1 i%0d rst ACK", i), int'(ack[i]), 0);
         chk($sformatf("s1 i%0d rst BUSY", i), int'(busy[i]), 0);
      end
      cycle(1'b0, 1'b0);
      run(6);
      e = '{0, 1, 2, 3};
      for (int i = 0; i < NI; i++) chk_q($sformatf("s1 i%0d order", i), log_p[i], e);

      // round-robin fairness, single-word bursts, one word per cycle
      start();
      for (int p = 0; p < N; p++) load(p, 3, p * 16, 1);
      reset_pulse();
      run(12);
      e.delete();
      for (int k = 0; k < 12; k++) e.push_back(k % 4);
      for (int i = 0; i < NI; i++) chk_q($sformatf("s2 i%0d order", i), log_p[i], e);

      // burst lock: producer 2 five words, producer 0 waiting
      start();
      load(1, 1, 'h10, 1);
      reset_pulse();
      run(1);
      load(2, 5, 'h20, 0);
      load(0, 1, 'h00, 1);
      run(8);
      e = '{1, 2, 2, 2, 2, 2, 0};
      chk_q("s3 i0 order", log_p[0], e);
      e = '{1, 2, 2, 2, 2, 0, 2};
      chk_q("s3 i1 order", log_p[1], e);
      chk("s3 i0 busy writes", busy_wr[0], 4);
      chk("s3 i1 busy writes", busy_wr[1], 3);
      chk("s3 i1 cuts", cuts[1], 1);

      // FULL back-pressure mid-burst
      start();
      load(3, 6, 'h30, 0);
      reset_pulse();
      run(2);
      full_v = 1'b1;
      repeat (3) begin
         cycle(1'b1, 1'b0);
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("s4 i%0d full W_INC", i), int'(winc[i]), 0);
            chk($sformatf("s4 i%0d full BUSY", i), int'(busy[i]), 1);
         end
      end
      full_v = 1'b0;
      run(6);
      e = '{3, 3, 3, 3, 3, 3};
      d = '{'h30, 'h31, 'h32, 'h33, 'h34, 'h35};
      for (int i = 0; i < NI; i++) begin
         chk_q($sformatf("s4 i%0d order", i), log_p[i], e);
         chk_q($sformatf("s4 i%0d data", i), log_d[i], d);
      end
      chk("s4 i0 cuts", cuts[0], 0);
      chk("s4 i1 cuts", cuts[1], 1);

      // forced release: producer 1 streams ten words, producer 3 has a two-word burst
      start();
      load(1, 10, 'h10, 2);
      load(3, 2, 'h30, 0);
      reset_pulse();
      run(16);
      e.delete();
      d.delete();
      for (int k = 0; k < 10; k++) begin
         e.push_back(1);
         d.push_back('h10 + k);
      end
      chk_q("s5 i0 order", log_p[0], e);
      chk_q("s5 i0 data", log_d[0], d);
      e = '{1, 1, 1, 1, 3, 3, 1, 1, 1, 1, 1, 1};
      d = '{'h10, 'h11, 'h12, 'h13, 'h30, 'h31, 'h14, 'h15, 'h16, 'h17, 'h18, 'h19};
      chk_q("s5 i1 order", log_p[1], e);
      chk_q("s5 i1 data", log_d[1], d);
      chk("s5 i0 cuts", cuts[0], 0);
      chk("s5 i1 cuts", cuts[1], 2);
      chk("s5 i1 first cut after", cut_at[1], 4);

      // asynchronous reset during the third word of a burst
      start();
      load(2, 1, 'h2A, 1);
      reset_pulse();
      run(1);
      load(2, 5, 'h20, 0);
      run(2);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      load(3, 1, 'h3F, 1);
      run(1);
      for (int i = 0; i < NI; i++) chk($sformatf("s6 i%0d GNT_ID after rst", i), int'(gnt[i]), 2);
      run(6);
      e = '{2, 2, 2, 2, 2, 2, 3};
      d = '{'h2A, 'h20, 'h21, 'h22, 'h23, 'h24, 'h3F};
      for (int i = 0; i < NI; i++) begin
         chk_q($sformatf("s6 i%0d order", i), log_p[i], e);
         chk_q($sformatf("s6 i%0d data", i), log_d[i], d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the asynchronous FIFO among `N_REQ` producers in the write clock domain. Each producer presents words with a last-of-burst marker. The arbiter locks the FIFO write port to one producer for a whole burst, or until a burst-length cap forces a hand-off. It drives the FIFO's write increment and write data, and it back-pressures producers from the FIFO full flag.

## Interface
Parameters:
- `N_REQ`, 4: number of producers; legal range 2–16.
- `DATA_WIDTH`, 8: FIFO word width; must match the FIFO.
- `MAX_BURST`, 16: maximum number of words accepted per grant before a forced release; must be ≥1.

Ports:
- `CLK`, in, 1: write-domain clock; drives the FIFO write clock.
- `RST`, in, 1: reset, asynchronous, active-low.
- `REQ`, in, `N_REQ`: per-producer word valid.
- `REQ_DATA`, in, `N_REQ*DATA_WIDTH`: producer i owns bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `REQ_LAST`, in, `N_REQ`: the current word is the last word of its burst.
- `ACK`, out, `N_REQ`: one-hot; the word is accepted this cycle.
- `FULL`, in, 1: FIFO full flag, already synchronised to `CLK`.
- `W_INC`, out, 1: FIFO write increment.
- `WR_DATA`, out, `DATA_WIDTH`: FIFO write data.
- `GNT_ID`, out, `clog2(N_REQ)`: index of the current or next granted producer.
- `BUSY`, out, 1: arbiter is in a locked burst.
- `BURST_CUT`, out, 1: one-cycle pulse on a forced release.

## Operation
- State machine, two states:
  - `IDLE`: the arbiter picks a winner combinationally. It searches `REQ` round-robin starting at `rr_ptr`.
  - `LOCK`: the winner is frozen in `gnt_q`. Other producers' requests are ignored.
- Accept condition: `accept = REQ[g] & ~FULL`, where `g` is the winner in `IDLE` or `gnt_q` in `LOCK`.
- When `accept` is true:
  - `W_INC=1`.
  - `WR_DATA=REQ_DATA[g]`.
  - `ACK[g]=1`.
- Otherwise `W_INC=0`, `ACK=0`, and `WR_DATA` = the selected producer's data (don't-care).
- `W_INC` is never asserted while `FULL=1`. No words are dropped.
- `burst_cnt` counts accepted words in the current grant. Width is `clog2(MAX_BURST+1)`. It clears on every release.
- Transitions:
  - `IDLE`, accept, `REQ_LAST=0`, `MAX_BURST>1`: go to `LOCK`. Set `gnt_q=g` and `burst_cnt=1`.
  - `IDLE`, accept, `REQ_LAST=1` (or `MAX_BURST=1`): stay in `IDLE`. Set `rr_ptr=g+1` mod `N_REQ`.
  - `LOCK`, accept, `REQ_LAST=1`: release. Go to `IDLE` with `rr_ptr=gnt_q+1`.
  - `LOCK`, accept, `REQ_LAST=0`, `burst_cnt+1==MAX_BURST`: forced release. Go to `IDLE`, set `rr_ptr=gnt_q+1`, and pulse `BURST_CUT` next cycle. The producer's remaining words re-arbitrate as a new burst.
  - `LOCK`, no accept (`REQ` low or `FULL`): hold state. The lock persists indefinitely; producers must not abandon a burst.
- `IDLE` with no `REQ`: no change. `rr_ptr` does not move.
- `GNT_ID` shows `gnt_q` in `LOCK` and the combinational winner in `IDLE`. It shows `rr_ptr` if nothing is requesting.
- `BUSY=1` exactly when the state is `LOCK`.

## Timing
- Acceptance has zero latency: `ACK`, `W_INC` and `WR_DATA` are combinational from `REQ`, `FULL` and state within the same cycle.
- The FIFO captures data on the `CLK` edge where `W_INC=1`.
- `FULL` takes effect in the same cycle it is seen.
- The producer advances to its next word on the edge after `ACK`.
- A producer holds `REQ`, `REQ_DATA` and `REQ_LAST` stable until `ACK`.
- Back-to-back single-word bursts from different producers sustain one word per cycle.
- Reset (`RST=0`, asynchronous):
  - state=`IDLE`, `rr_ptr=0`, `gnt_q=0`, `burst_cnt=0`, `BURST_CUT=0`.
  - `W_INC` and `ACK` are forced 0 while `RST=0`.
- Reset mid-burst aborts the lock. No partial-burst recovery is performed.
- Reset of the FIFO write side and of this block must be asserted together.

## Structure
- Shared package `fifo_arb_pkg`:
  - State enum `{IDLE, LOCK}`.
  - Width helper functions for the `clog2`-based index and count widths.
- One sub-module, `rr_pick`: a combinational round-robin priority encoder. Inputs are `req[N_REQ]` and `ptr`. Outputs are `idx` and `found`.
- The top holds the FSM, `burst_cnt` and the datapath mux.

## Test plan
- Reset: hold `RST=0` with all `REQ=1`. Expect `W_INC=0`, `ACK=0`, `BUSY=0`. After release, the first accepted producer is producer 0.
- Round-robin fairness: `N_REQ=4` with all producers continuously requesting single-word bursts (`REQ_LAST=1`). Expect `ACK` to cycle 0,1,2,3,0… with one word per cycle.
- Burst lock: producer 2 sends a 5-word burst, last word on word 5, while producer 0 requests throughout. Expect producer 2's 5 words to arrive contiguously with `BUSY=1` for words 2–5. Producer 0 is accepted next.
- Full back-pressure: assert `FULL` for 3 cycles mid-burst. Expect `W_INC=0`, `ACK=0`, and state held. The burst resumes with no word lost or duplicated, verified against a FIFO scoreboard.
- Forced release: `MAX_BURST=4`, producer 1 streams 10 words with no `REQ_LAST`, producer 3 requesting. Expect:
  - Words 1–4 from producer 1, then `BURST_CUT` pulses once.
  - Producer 3's burst, then producer 1 resumes with word 5.
- Async reset mid-burst: drop `RST` during the third word of a burst. Expect outputs to go to 0 immediately. After release, state=`IDLE` and `rr_ptr=0`.
